// File: rtl/mem_pkg.sv
// Shared types for the memory-stage controller: access widths, FSM states
// and the alignment rule applied at request accept.
package mem_pkg;

    typedef enum logic [1:0] {
        WT_NONE = 2'b00,
        WT_32   = 2'b01,
        WT_36   = 2'b10,
        WT_128  = 2'b11
    } wtype_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_WAIT,
        RESP
    } mem_ctrl_state_t;

    localparam int LINE_BYTES = 16;

    // word = addr[3:2]; the byte offset addr[1:0] never affects alignment.
    function automatic logic is_misaligned(input logic [1:0] wtype, input logic [1:0] word);
        return ((wtype_t'(wtype) == WT_128) && (word != 2'b00)) ||
               ((wtype_t'(wtype) == WT_36) && word[0]);
    endfunction

endpackage

// File: rtl/mem_miss_timer.sv
// Watchdog counter for the miss wait: cleared on entry, counts each waiting
// cycle, and flags expiry in the cycle that completes TIMEOUT waiting cycles.
module mem_miss_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// Memory-stage controller: one load/store at a time through the data cache.
// Optional miss watchdog enabled by defining MEM_CTRL_WATCHDOG_EN.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 36,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_wtype,
    input  logic [127:0]      req_wdata,
    output logic              cache_req,
    output logic              cache_we,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [127:0]      cache_wdata,
    input  logic              cache_hit,
    input  logic              cache_fill_done,
    output logic [1:0]        line,
    output logic [1:0]        w_type,
    output logic              mem_operation,
    output logic              wb_valid,
    output logic              stall,
    output logic              err
);

    // Handshake: a request transfers in any cycle with req_valid && req_ready;
    // req_ready is high only in IDLE, and req_valid is ignored elsewhere.

    mem_ctrl_state_t   state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    wtype_t            wtype_q;
    logic [127:0]      wdata_q;
    logic              err_q;

    logic accept;
    logic misaligned;
    logic skip_cache;
    logic miss_expired;
    logic timeout_err;

    assign misaligned  = is_misaligned(req_wtype, req_addr[3:2]);
    assign skip_cache  = (wtype_t'(req_wtype) == WT_NONE) || misaligned;
    assign timeout_err = (state == MISS_WAIT) && !cache_fill_done && miss_expired;

`ifdef MEM_CTRL_WATCHDOG_EN
    logic timer_clear;
    logic timer_en;

    assign timer_clear = (state == LOOKUP) && !cache_hit;
    assign timer_en    = (state == MISS_WAIT);

    mem_miss_timer #(
        .TIMEOUT(MISS_TIMEOUT)
    ) u_miss_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .en     (timer_en),
        .expired(miss_expired)
    );
`else
    // Without the watchdog a miss waits for its fill indefinitely.
    assign miss_expired = 1'b0 && (MISS_TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        accept        = 1'b0;
        req_ready     = 1'b0;
        stall         = 1'b1;
        cache_req     = 1'b0;
        cache_we      = 1'b0;
        wb_valid      = 1'b0;
        mem_operation = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = skip_cache ? RESP : LOOKUP;
                end
            end
            LOOKUP: begin
                cache_req = 1'b1;
                cache_we  = write_q;
                state_n   = cache_hit ? RESP : MISS_WAIT;
            end
            MISS_WAIT: begin
                // A fill arriving on the expiry cycle wins and retries.
                if (cache_fill_done) begin
                    state_n = LOOKUP;
                end else if (miss_expired) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                wb_valid      = 1'b1;
                mem_operation = !write_q && (wtype_q != WT_NONE) && !err_q;
                state_n       = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wtype_q <= WT_NONE;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wtype_q <= wtype_t'(req_wtype);
            wdata_q <= req_wdata;
            err_q   <= misaligned;
        end else if (timeout_err) begin
            err_q   <= 1'b1;
        end
    end

    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;
    assign line        = addr_q[3:2];
    assign w_type      = wtype_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a driver walks each request cycle by cycle and
// queues the expected writeback; a monitor checks every wb_valid against it.
module tb_mem_ctrl;

    localparam int ADDR_W = 36;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_wtype;
    logic [127:0]      req_wdata;
    logic              cache_req;
    logic              cache_we;
    logic [ADDR_W-1:0] cache_addr;
    logic [127:0]      cache_wdata;
    logic              cache_hit;
    logic              cache_fill_done;
    logic [1:0]        line;
    logic [1:0]        w_type;
    logic              mem_operation;
    logic              wb_valid;
    logic              stall;
    logic              err;

    // Expected writeback: {err, mem_operation, w_type, line}
    logic [5:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    mem_ctrl #(
        .ADDR_W      (ADDR_W),
        .MISS_TIMEOUT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wtype      (req_wtype),
        .req_wdata      (req_wdata),
        .cache_req      (cache_req),
        .cache_we       (cache_we),
        .cache_addr     (cache_addr),
        .cache_wdata    (cache_wdata),
        .cache_hit      (cache_hit),
        .cache_fill_done(cache_fill_done),
        .line           (line),
        .w_type         (w_type),
        .mem_operation  (mem_operation),
        .wb_valid       (wb_valid),
        .stall          (stall),
        .err            (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [1:0] wt, input logic [127:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wtype = wt;
        req_wdata = wd;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [5:0] e;
        #2;
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_resp", {err, mem_operation, w_type, line}, e);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        logic [127:0] wd;
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = '0;
        req_wtype       = 2'b00;
        req_wdata       = '0;
        cache_hit       = 1'b0;
        cache_fill_done = 1'b0;

        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_outputs", {cache_req, cache_we, wb_valid, stall, err, mem_operation}, 0);
        chk("rst_line_wtype", {line, w_type}, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Load hit at 0x108, 32-bit
        cyc(); issue(1'b0, 'h108, 2'b01, '0); exp_q.push_back({1'b0, 1'b1, 2'b01, 2'd2});
        #1 chk("t1_ready", req_ready, 1); chk("t1_stall_accept", stall, 1); chk("t1_no_req", cache_req, 0);
        cyc(); req_valid = 1'b0; cache_hit = 1'b1;
        #1 chk("t1_cache_req", cache_req, 1); chk("t1_cache_we", cache_we, 0); chk("t1_addr", cache_addr, 'h108);
        cyc(); cache_hit = 1'b0;
        #1 chk("t1_wb", wb_valid, 1); chk("t1_stall_resp", stall, 1);
        cyc();
        #1 chk("t1_stall_idle", stall, 0); chk("t1_line_hold", line, 2);

        // Store miss at 0x200, 128-bit, fill in N+5
        wd = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        cyc(); issue(1'b1, 'h200, 2'b11, wd); exp_q.push_back({1'b0, 1'b0, 2'b11, 2'd0});
        #1 chk("t2_stall_n", stall, 1);
        cyc(); req_valid = 1'b0;
        #1 chk("t2_lookup_req", cache_req, 1); chk("t2_lookup_we", cache_we, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 chk("t2_wait_req", cache_req, 0); chk("t2_wait_stall", stall, 1);
        end
        cyc(); cache_fill_done = 1'b1;
        #1 chk("t2_fill_req", cache_req, 0); chk("t2_fill_wb", wb_valid, 0);
        cyc(); cache_fill_done = 1'b0; cache_hit = 1'b1;
        #1 chk("t2_retry_req", cache_req, 1); chk("t2_retry_we", cache_we, 1); chk("t2_wdata", cache_wdata, wd);
        cyc(); cache_hit = 1'b0;
        #1 chk("t2_wb", wb_valid, 1); chk("t2_stall_n7", stall, 1);
        cyc();
        #1 chk("t2_stall_idle", stall, 0);

        // Misaligned 36-bit load at 0x104
        cyc(); issue(1'b0, 'h104, 2'b10, '0); exp_q.push_back({1'b1, 1'b0, 2'b10, 2'd1});
        #1 chk("t3_no_req_n", cache_req, 0);
        cyc(); req_valid = 1'b0;
        #1 chk("t3_no_req", cache_req, 0); chk("t3_wb", wb_valid, 1); chk("t3_err", err, 1);
        cyc();
        #1 chk("t3_err_hold", err, 1); chk("t3_wb_low", wb_valid, 0);

        // No-op store at 0x0C
        cyc(); issue(1'b1, 'h00C, 2'b00, '1); exp_q.push_back({1'b0, 1'b0, 2'b00, 2'd3});
        cyc(); req_valid = 1'b0;
        #1 chk("t4_wb", wb_valid, 1); chk("t4_no_req", cache_req, 0);
        cyc();

        // Stray fill in IDLE ignored; 128-bit load at 0x103 is aligned
        cyc(); cache_fill_done = 1'b1;
        #1 chk("t5_stray_fill", cache_req, 0);
        cyc(); cache_fill_done = 1'b0;
        #1 chk("t5_still_idle", req_ready, 1);
        cyc(); issue(1'b0, 'h103, 2'b11, '0); exp_q.push_back({1'b0, 1'b1, 2'b11, 2'd0});
        cyc(); req_valid = 1'b0; cache_hit = 1'b1;
        #1 chk("t5_aligned_req", cache_req, 1);
        cyc(); cache_hit = 1'b0;
        cyc();

        // Misaligned 128-bit store at 0x108
        cyc(); issue(1'b1, 'h108, 2'b11, '0); exp_q.push_back({1'b1, 1'b0, 2'b11, 2'd2});
        cyc(); req_valid = 1'b0;
        #1 chk("t6_no_req", cache_req, 0);
        cyc();

        // Back-to-back loads with req_valid held high
        cyc(); issue(1'b0, 'h208, 2'b10, '0); exp_q.push_back({1'b0, 1'b1, 2'b10, 2'd2});
        cyc(); issue(1'b0, 'h40C, 2'b01, '0); cache_hit = 1'b1; exp_q.push_back({1'b0, 1'b1, 2'b01, 2'd3});
        #1 chk("t7_busy_ready", req_ready, 0); chk("t7_addr_a", cache_addr, 'h208);
        cyc(); cache_hit = 1'b0;
        #1 chk("t7_wb_a", wb_valid, 1); chk("t7_resp_ready", req_ready, 0);
        cyc();
        #1 chk("t7_accept_b", req_ready, 1); chk("t7_stall_b", stall, 1);
        cyc(); req_valid = 1'b0; cache_hit = 1'b1;
        #1 chk("t7_addr_b", cache_addr, 'h40C);
        cyc(); cache_hit = 1'b0;
        cyc();

        // Load at 0x310 misses twice
        cyc(); issue(1'b0, 'h310, 2'b01, '0); exp_q.push_back({1'b0, 1'b1, 2'b01, 2'd0});
        cyc(); req_valid = 1'b0;
        cyc(); cache_fill_done = 1'b1;
        cyc(); cache_fill_done = 1'b0;
        #1 chk("t8_retry1", cache_req, 1);
        cyc();
        #1 chk("t8_rewait_req", cache_req, 0); chk("t8_rewait_stall", stall, 1);
        cyc(); cache_fill_done = 1'b1;
        cyc(); cache_fill_done = 1'b0; cache_hit = 1'b1;
        #1 chk("t8_retry2", cache_req, 1);
        cyc(); cache_hit = 1'b0;
        #1 chk("t8_wb", wb_valid, 1);
        cyc();

`ifdef MEM_CTRL_WATCHDOG_EN
        // Timeout four cycles after MISS_WAIT entry
        cyc(); issue(1'b0, 'h300, 2'b01, '0); exp_q.push_back({1'b1, 1'b0, 2'b01, 2'd0});
        cyc(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1 chk("t9_wait_wb", wb_valid, 0); chk("t9_wait_stall", stall, 1);
        end
        cyc();
        #1 chk("t9_timeout_wb", wb_valid, 1); chk("t9_timeout_err", err, 1);
        cyc();
        // Fill on the expiry cycle retries instead
        cyc(); issue(1'b0, 'h304, 2'b01, '0); exp_q.push_back({1'b0, 1'b1, 2'b01, 2'd1});
        cyc(); req_valid = 1'b0;
        cyc(); cyc(); cyc();
        cyc(); cache_fill_done = 1'b1;
        cyc(); cache_fill_done = 1'b0; cache_hit = 1'b1;
        #1 chk("t9_fill_wins_req", cache_req, 1); chk("t9_fill_wins_wb", wb_valid, 0);
        cyc(); cache_hit = 1'b0;
        #1 chk("t9_fill_wins_done", wb_valid, 1);
        cyc();
`else
        // Without the watchdog a miss waits as long as the fill takes
        cyc(); issue(1'b0, 'h300, 2'b01, '0); exp_q.push_back({1'b0, 1'b1, 2'b01, 2'd0});
        cyc(); req_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            #1 chk("t9_long_wait", {stall, wb_valid, cache_req}, 3'b100);
        end
        cyc(); cache_fill_done = 1'b1;
        cyc(); cache_fill_done = 1'b0; cache_hit = 1'b1;
        cyc(); cache_hit = 1'b0;
        #1 chk("t9_late_wb", wb_valid, 1); chk("t9_no_err", err, 0);
        cyc();
`endif

        // Reset while in MISS_WAIT: op discarded
        cyc(); issue(1'b0, 'h50C, 2'b01, '0);
        cyc(); req_valid = 1'b0;
        cyc();
        #1 chk("t10_in_wait", stall, 1);
        #2 rst = 1'b1;
        #1 chk("t10_rst_stall", stall, 0); chk("t10_rst_req", cache_req, 0); chk("t10_rst_wb", wb_valid, 0);
        cyc(); rst = 1'b0;
        #1 chk("t10_ready", req_ready, 1); chk("t10_line", line, 0); chk("t10_wtype", w_type, 0);

        // Reset while in LOOKUP
        cyc(); issue(1'b1, 'h020, 2'b01, '0);
        cyc(); req_valid = 1'b0;
        #1 chk("t11_lookup", cache_req, 1);
        #2 rst = 1'b1;
        #1 chk("t11_rst_req", cache_req, 0); chk("t11_rst_stall", stall, 0);
        cyc(); rst = 1'b0;
        #1 chk("t11_ready", req_ready, 1); chk("t11_we", cache_we, 0);

        for (int i = 0; i < 4; i++) cyc();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-stage controller that sequences one load/store at a time through the data cache and drives the writeback mux selects (`line`, `w_type`, `mem_operation`) of the `mem` stage. It sits between the execute stage and the data cache. It accepts a request, performs the cache lookup, stalls the pipeline across misses until the fill completes, then retries and presents a one-cycle writeback strobe.

## Interface
Parameters:
- `ADDR_W`, 36, byte-address width.
- `MISS_TIMEOUT`, 1024, cycles allowed in MISS_WAIT. Used only with the watchdog.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  execute stage presents a memory op.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_wtype`  in  2  00 none, 01 32-bit, 10 36-bit, 11 128-bit.
- `req_wdata`  in  128  store data.
- `cache_req`  out  1  lookup/write strobe to the data cache.
- `cache_we`  out  1  write enable, qualified by `cache_req`.
- `cache_addr`  out  ADDR_W  latched address.
- `cache_wdata`  out  128  latched store data.
- `cache_hit`  in  1  valid in the same cycle as `cache_req`.
- `cache_fill_done`  in  1  one-cycle pulse; the miss fill has completed.
- `line`  out  2  word select to the `mem` stage, equal to latched `addr[3:2]`.
- `w_type`  out  2  latched `req_wtype`.
- `mem_operation`  out  1  1 in RESP for a non-faulting load with `w_type != 00`.
- `wb_valid`  out  1  one-cycle completion strobe.
- `stall`  out  1  freezes upstream stages.
- `err`  out  1  qualified by `wb_valid`; flags misalignment or timeout.

## Operation
States:
- **IDLE**
  - `req_ready = 1`.
  - On `req_valid`, latch addr, write, wtype and wdata.
  - `wtype == 00` → RESP without a cache access.
  - Misaligned → RESP with `err`, no cache access. Misaligned means: wtype 11 with `addr[3:2] != 0`, or wtype 10 with `addr[2] != 0`. `addr[1:0]` is ignored.
  - Otherwise → LOOKUP.
- **LOOKUP**
  - `cache_req = 1`; `cache_we = write`.
  - `cache_hit` → RESP.
  - Miss → MISS_WAIT.
- **MISS_WAIT**
  - `cache_req = 0`.
  - `cache_fill_done` → LOOKUP (retry; write-allocate applies to stores too).
- **RESP**
  - `wb_valid = 1`.
  - `mem_operation = !write && wtype != 00 && !err`.
  - → IDLE.

Output rules:
- `stall = (state != IDLE) || (state == IDLE && req_valid && accepted)`. In other words, stall rises in the accept cycle and stays high through RESP.
- `line`, `w_type` and `err` hold their latched values from accept until the next accept.
- `cache_fill_done` outside MISS_WAIT is ignored.
- `req_valid` outside IDLE is ignored; `req_ready = 0`.

## Timing
- Reset values:
  - state IDLE, `req_ready = 1`.
  - All other outputs are 0, including `line`, `w_type` and all latches.
- Asynchronous reset mid-operation: `cache_req`, `wb_valid` and `stall` drop immediately. The in-flight op is discarded; nothing is replayed.
- Hit latency: accept in cycle N, `cache_req` in N+1, `wb_valid` in N+2. Back-to-back accept is possible in N+3.
- Miss latency: `wb_valid` comes 2 cycles after the `cache_fill_done` pulse, via a retry LOOKUP. A second miss on the retry re-enters MISS_WAIT.
- The no-op and misaligned paths give `wb_valid` in N+1.
- `cache_hit` is sampled only in LOOKUP.

## Configuration
Macro: `MEM_CTRL_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on entry to MISS_WAIT and increments each cycle spent there.
  - When it reaches `MISS_TIMEOUT`, the controller goes to RESP with `err = 1` and `mem_operation = 0`.
  - `cache_fill_done` in the same cycle wins over the timeout.
- **Undefined:**
  - No counter; MISS_WAIT waits indefinitely.
  - `err` is asserted only for misalignment.

## Structure
- Shared package `mem_pkg`:
  - `wtype_t` enum (`WT_NONE`, `WT_32`, `WT_36`, `WT_128`).
  - `mem_ctrl_state_t` enum (IDLE, LOOKUP, MISS_WAIT, RESP).
  - `LINE_BYTES = 16`.
- Sub-module `mem_miss_timer` holds the watchdog counter (clear/enable/expired). It is instantiated only under `MEM_CTRL_WATCHDOG_EN`.

## Test plan
- Load hit: `addr = 0x108`, wtype 01, hit → `cache_req` at N+1; at N+2 `wb_valid = 1`, `line = 2`, `w_type = 01`, `mem_operation = 1`.
- Store miss: `addr = 0x200`, wtype 11, miss, `cache_fill_done` at N+5 → LOOKUP at N+6 with `cache_we = 1`; hit → `wb_valid` at N+7 with `mem_operation = 0`; `stall` high N..N+7.
- Misaligned: wtype 10 at `addr = 0x104` → no `cache_req`; `wb_valid` and `err` at N+1.
- Reset asserted in MISS_WAIT → `stall` and `cache_req` drop immediately; after release, `req_ready = 1` and `line = 0`.
- Watchdog enabled, `MISS_TIMEOUT = 4`, no fill → `wb_valid` with `err = 1` 4 cycles after MISS_WAIT entry. With a fill pulse on the expiry cycle → retry LOOKUP instead.
